modulator_mpsk: RTL and testbench
=================================

# modulator_mpsk

Parametrised M-ary PSK symbol mapper that drains bytes from a first-word-fall-through FIFO and presents a phase index to the carrier stage. Each sample is cut into k-bit symbols, optionally Gray-mapped and differentially encoded. Each phase is held for a fixed number of clocks. It generalises the 1-bit serialising modulator to k bits per symbol, selectable bit order, DPSK, and explicit busy/underrun reporting.

## Interface
- SAMPLE_WIDTH, 8: FIFO word width.
- BITS_PER_SYMBOL, 2: k, bits per PSK symbol. Must divide SAMPLE_WIDTH: 1, 2, 4 or 8 for the default width.
- CLKS_PER_SYMBOL, 4: clocks each phase is held. Must be ≥ 1.
- clk  in  1  single clock. All logic is on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  clock enable. When low, all state freezes.
- sample  in  SAMPLE_WIDTH  FIFO head word, valid while empty=0.
- empty  in  1  FIFO empty flag.
- read  out  1  one-cycle FIFO pop, registered.
- msb_first  in  1  0: low symbol first. 1: high symbol first.
- gray_en  in  1  Gray-map each symbol.
- diff_en  in  1  differential (DPSK) encoding.
- phase  out  BITS_PER_SYMBOL  phase index, registered.
- symbol_strobe  out  1  one-cycle pulse when phase takes a new symbol.
- busy  out  1  high while in RUN.
- underrun  out  1  one-cycle pulse when the stream ends because the FIFO is empty.

## Operation
- Symbol count per word: N = SAMPLE_WIDTH / k.
- Counters:
  - clk counter: width max(1, clog2(CLKS_PER_SYMBOL)), counts 0..CLKS_PER_SYMBOL-1.
  - symbol counter: width max(1, clog2(N)), counts 0..N-1.
- States: IDLE, RUN. Any illegal state returns to IDLE.
- Load (one clock edge):
  - read←1.
  - The shift register captures sample. msb_first, gray_en and diff_en are latched here and stay constant for the whole word.
  - Both counters←0.
  - phase←f(first symbol). symbol_strobe←1.
- Symbol extraction:
  - msb_first=0: bits [k-1:0], then shift right by k.
  - msb_first=1: bits [W-1:W-k], then shift left by k.
- Mapping f(s):
  - g = gray_en ? s^(s>>1) : s.
  - If diff_en: acc←(acc+g) mod 2^k and phase=acc+g. Otherwise phase=g.
  - acc always tracks the last emitted phase, including when diff_en=0.
- IDLE: when enable=1 and empty=0, perform Load and go to RUN.
- RUN, per enabled clock:
  - If the clk counter is below CLKS_PER_SYMBOL-1, increment it.
  - Else, if the symbol counter is below N-1: advance the shift register, increment the symbol counter, clear the clk counter, phase←f(next), strobe←1.
  - Else (last clock of last symbol):
    - empty=0: Load again, with no gap.
    - empty=1: go to IDLE, underrun←1.
- IDLE holds phase and acc at their last values.
- enable=0: no counting, no state change; read, symbol_strobe and underrun are forced 0; phase and busy hold.
- Reset values: state IDLE, counters 0, shift register 0, acc 0, phase 0, read 0, symbol_strobe 0, busy 0, underrun 0.

## Timing
- Start latency: empty=0 with enable=1 sampled at edge E in IDLE → read, strobe, busy and the first phase all valid after E. The FIFO pops at the next edge.
- Each phase is held exactly CLKS_PER_SYMBOL enabled cycles. One word lasts N·CLKS_PER_SYMBOL enabled cycles.
- Back-to-back words: read pulses exactly N·CLKS_PER_SYMBOL enabled cycles apart. There is no idle cycle between words.
- Simultaneous events:
  - empty rising on the same edge as a reload request: that edge ends the stream (underrun), since empty is sampled at that edge.
  - enable low on the last cycle delays the reload/underrun decision until enable returns.
- Underrun pulse: coincides with busy falling. If data returns, a new word can load on the very next enabled edge.
- Reset mid-symbol: all outputs return to their reset values immediately (asynchronous). No read is issued. Operation restarts from IDLE after rst deasserts.
- With CLKS_PER_SYMBOL=1, a new phase and strobe appear every cycle.

## Test plan
- k=2, CLKS=4, modes 0/0/0, one word 0xB4 then empty → phase 0,1,3,2, each for 4 cycles. One read. Strobe at cycles 0,4,8,12. underrun at cycle 16, busy falls, phase holds 2.
- Same word with msb_first=1 → phase 2,3,1,0. With gray_en=1 (lsb-first) → phase 0,1,2,3.
- gray_en=1, diff_en=1, word 0xB4, acc=0 from reset → phase 0,1,3,2.
- Three words queued (0x00, 0xFF, 0x1B), k=2 → reads 16 cycles apart, no gap. Phases 0,0,0,0, then 3,3,3,3, then 3,2,1,0.
- enable low for 5 cycles during the 2nd clock of symbol 1 → that symbol lasts 9 cycles. No strobe, read or underrun while enable is low.
- k=1, CLKS=1, word 0xA5, lsb-first → phase 1,0,1,0,0,1,0,1 on consecutive cycles. Reset asserted mid-word → phase=0, busy=0 immediately, no read until empty=0 after reset release.

Source files
------------

// File: rtl/modulator_mpsk.sv
// M-ary PSK symbol mapper: pops words from a FWFT FIFO, slices each into
// k-bit symbols, optionally Gray-maps and differentially encodes them, and
// holds each resulting phase index for CLKS_PER_SYMBOL enabled clocks.
module modulator_mpsk #(
    parameter int SAMPLE_WIDTH    = 8,
    parameter int BITS_PER_SYMBOL = 2,
    parameter int CLKS_PER_SYMBOL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [SAMPLE_WIDTH-1:0]    sample,
    input  logic                       empty,
    output logic                       read,
    input  logic                       msb_first,
    input  logic                       gray_en,
    input  logic                       diff_en,
    output logic [BITS_PER_SYMBOL-1:0] phase,
    output logic                       symbol_strobe,
    output logic                       busy,
    output logic                       underrun
);

    localparam int W  = SAMPLE_WIDTH;
    localparam int K  = BITS_PER_SYMBOL;
    localparam int N  = SAMPLE_WIDTH / BITS_PER_SYMBOL;
    localparam int CW = (CLKS_PER_SYMBOL > 1) ? $clog2(CLKS_PER_SYMBOL) : 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_SYMBOL - 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [W-1:0]  shreg, shreg_next, shreg_shifted;
    logic [CW-1:0] clk_cnt, clk_next;
    logic [SW-1:0] sym_cnt, sym_next;
    logic [K-1:0]  acc, acc_next;
    logic [K-1:0]  phase_next;
    logic          msb_q, gray_q, diff_q;
    logic          msb_next, gray_next, diff_next;
    logic          read_next, strobe_next, underrun_next;
    logic          load, advance;

    // Current symbol of a word for the given bit order.
    function automatic logic [K-1:0] pick(input logic [W-1:0] word, input logic msb);
        return msb ? word[W-1 -: K] : word[K-1:0];
    endfunction

    // Gray mapping followed by optional differential accumulation.
    function automatic logic [K-1:0] map_symbol(input logic [K-1:0] s,
                                                input logic gray,
                                                input logic diff,
                                                input logic [K-1:0] prev);
        logic [K-1:0] g;
        g = gray ? (s ^ (s >> 1)) : s;
        return diff ? (prev + g) : g;
    endfunction

    // Busy is a pure decode of the state register.
    assign busy = (state == RUN);

    // Next-state, counter, shift-register and output computation.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        clk_next      = clk_cnt;
        sym_next      = sym_cnt;
        acc_next      = acc;
        phase_next    = phase;
        msb_next      = msb_q;
        gray_next     = gray_q;
        diff_next     = diff_q;
        read_next     = 1'b0;
        strobe_next   = 1'b0;
        underrun_next = 1'b0;
        load          = 1'b0;
        advance       = 1'b0;
        shreg_shifted = msb_q ? (shreg << K) : (shreg >> K);

        if (enable) begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        load = 1'b1;
                    end
                end
                RUN: begin
                    if (clk_cnt != CLK_LAST) begin
                        clk_next = clk_cnt + 1'b1;
                    end else if (sym_cnt != SYM_LAST) begin
                        advance = 1'b1;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_next    = IDLE;
                        underrun_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Loading uses the live mode inputs; they are frozen for the word.
        if (load) begin
            state_next  = RUN;
            read_next   = 1'b1;
            strobe_next = 1'b1;
            shreg_next  = sample;
            clk_next    = '0;
            sym_next    = '0;
            msb_next    = msb_first;
            gray_next   = gray_en;
            diff_next   = diff_en;
            phase_next  = map_symbol(pick(sample, msb_first), gray_en, diff_en, acc);
            acc_next    = phase_next;
        end

        if (advance) begin
            strobe_next = 1'b1;
            shreg_next  = shreg_shifted;
            clk_next    = '0;
            sym_next    = sym_cnt + 1'b1;
            phase_next  = map_symbol(pick(shreg_shifted, msb_q), gray_q, diff_q, acc);
            acc_next    = phase_next;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            clk_cnt       <= '0;
            sym_cnt       <= '0;
            acc           <= '0;
            phase         <= '0;
            msb_q         <= 1'b0;
            gray_q        <= 1'b0;
            diff_q        <= 1'b0;
            read          <= 1'b0;
            symbol_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state         <= state_next;
            shreg         <= shreg_next;
            clk_cnt       <= clk_next;
            sym_cnt       <= sym_next;
            acc           <= acc_next;
            phase         <= phase_next;
            msb_q         <= msb_next;
            gray_q        <= gray_next;
            diff_q        <= diff_next;
            read          <= read_next;
            symbol_strobe <= strobe_next;
            underrun      <= underrun_next;
        end
    end

endmodule

// File: tb/tb_modulator_mpsk.sv
// Self-checking bench for modulator_mpsk: table vectors, hand sequences and
// randomized bursts checked cycle by cycle against a symbol-timeline model.
`timescale 1ns/1ps
module tb_modulator_mpsk;

    localparam int W    = 8;
    localparam int K    = 2;
    localparam int CLKS = 4;
    localparam int NSYM = W / K;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable, empty, read, msb_first, gray_en, diff_en;
    logic         symbol_strobe, busy, underrun;
    logic [W-1:0] sample;
    logic [K-1:0] phase;

    logic         en1, empty1, read1, strobe1, busy1, underrun1;
    logic [7:0]   sample1;
    logic [0:0]   phase1;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo[$];
    int         exp_ph[$];
    int         hold_ph = 0;
    int         acc_m   = 0;

    typedef struct {
        logic [7:0]  word;
        logic        msb;
        logic        gray;
        logic        diff;
        logic [15:0] exp;   // one hex digit per symbol, first symbol leftmost
    } vec_t;
    vec_t vt[9];

    modulator_mpsk #(.SAMPLE_WIDTH(W), .BITS_PER_SYMBOL(K), .CLKS_PER_SYMBOL(CLKS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample(sample), .empty(empty),
        .read(read), .msb_first(msb_first), .gray_en(gray_en), .diff_en(diff_en),
        .phase(phase), .symbol_strobe(symbol_strobe), .busy(busy), .underrun(underrun)
    );

    modulator_mpsk #(.SAMPLE_WIDTH(8), .BITS_PER_SYMBOL(1), .CLKS_PER_SYMBOL(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .sample(sample1), .empty(empty1),
        .read(read1), .msb_first(1'b0), .gray_en(1'b0), .diff_en(1'b0),
        .phase(phase1), .symbol_strobe(strobe1), .busy(busy1), .underrun(underrun1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fifo_update();
        empty  = (fifo.size() == 0);
        sample = empty ? '0 : fifo[0];
    endtask

    // Reference mapping: slice, Gray, accumulate, one entry per symbol.
    function automatic void model_word(input logic [7:0] w, input bit msb, input bit gray, input bit diff);
        int wi, s, g, p, sh;
        wi = int'(w);
        for (int j = 0; j < NSYM; j++) begin
            sh = msb ? (W - K * (j + 1)) : (K * j);
            s  = (wi >> sh) & ((1 << K) - 1);
            g  = gray ? (s ^ (s >> 1)) : s;
            p  = diff ? ((acc_m + g) % (1 << K)) : g;
            acc_m = p;
            exp_ph.push_back(p);
        end
        fifo.push_back(w);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold_ph = 0;
        acc_m   = 0;
        fifo.delete();
        exp_ph.delete();
        fifo_update();
    endtask

    // Runs the queued words to underrun; i counts enabled edges since load.
    task automatic run_stream(input int en_pct, input int stall_at, input int stall_len, input string tag);
        int i, t, e_ph, e_busy, e_rd, e_st, e_un;
        bit en_now, done;
        i = -1;
        done = 1'b0;
        t = exp_ph.size() * CLKS;
        fifo_update();
        for (int cyc = 0; cyc < t * 8 + 64 && !done; cyc++) begin
            if (cyc >= stall_at && cyc < stall_at + stall_len)
                en_now = 1'b0;
            else
                en_now = (int'($urandom_range(0, 99)) < en_pct);
            enable = en_now;
            @(negedge clk);
            if (en_now) i++;
            e_rd = 0; e_st = 0; e_un = 0;
            if (i < 0) begin
                e_ph = hold_ph; e_busy = 0;
            end else if (i < t) begin
                e_ph = exp_ph[i / CLKS]; e_busy = 1;
                if (en_now) begin
                    e_st = (i % CLKS == 0) ? 1 : 0;
                    e_rd = (i % (NSYM * CLKS) == 0) ? 1 : 0;
                end
            end else begin
                e_ph = exp_ph[exp_ph.size() - 1]; e_busy = 0;
                e_un = 1; done = 1'b1;
            end
            chk({tag, " phase"},    int'(phase),         e_ph);
            chk({tag, " busy"},     int'(busy),          e_busy);
            chk({tag, " read"},     int'(read),          e_rd);
            chk({tag, " strobe"},   int'(symbol_strobe), e_st);
            chk({tag, " underrun"}, int'(underrun),      e_un);
            if (read) begin
                if (fifo.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s pop_empty: got read=1 expected read=0 (fifo empty)", tag);
                end else begin
                    void'(fifo.pop_front());
                end
            end
            fifo_update();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: got no underrun expected underrun within budget", tag);
        end
        hold_ph = exp_ph[exp_ph.size() - 1];
        exp_ph.delete();
        enable = 1'b1;
    endtask

    task automatic set_vec(input int idx, input logic [7:0] w, input bit m, input bit g,
                           input bit d, input logic [15:0] e);
        vt[idx].word = w; vt[idx].msb = m; vt[idx].gray = g; vt[idx].diff = d; vt[idx].exp = e;
    endtask

    initial begin
        int n, b1;
        logic [7:0] a5;
        rst = 1'b1; enable = 1'b1; msb_first = 1'b0; gray_en = 1'b0; diff_en = 1'b0;
        en1 = 1'b1; empty1 = 1'b1; sample1 = '0;
        fifo_update();

        set_vec(0, 8'hB4, 0, 0, 0, 16'h0132);
        set_vec(1, 8'hB4, 1, 0, 0, 16'h2310);
        set_vec(2, 8'hB4, 0, 1, 0, 16'h0123);
        set_vec(3, 8'hB4, 0, 1, 1, 16'h0132);
        set_vec(4, 8'hB4, 0, 0, 1, 16'h0102);
        set_vec(5, 8'hB4, 1, 1, 0, 16'h3210);
        set_vec(6, 8'h1B, 0, 0, 0, 16'h3210);
        set_vec(7, 8'hFF, 0, 1, 1, 16'h2020);
        set_vec(8, 8'h1B, 1, 0, 1, 16'h0132);

        repeat (2) @(negedge clk);
        chk("reset phase",    int'(phase),         0);
        chk("reset busy",     int'(busy),          0);
        chk("reset read",     int'(read),          0);
        chk("reset strobe",   int'(symbol_strobe), 0);
        chk("reset underrun", int'(underrun),      0);
        chk("reset busy1",    int'(busy1),         0);
        rst = 1'b0;
        @(negedge clk);

        // Single-word table vectors, each from a fresh reset.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            msb_first = vt[v].msb; gray_en = vt[v].gray; diff_en = vt[v].diff;
            fifo.push_back(vt[v].word);
            for (int j = 0; j < NSYM; j++)
                exp_ph.push_back(int'((vt[v].exp >> (4 * (NSYM - 1 - j))) & 16'hF));
            run_stream(100, -1, 0, "vec");
            @(negedge clk);
            chk("vec idle phase", int'(phase), hold_ph);
            chk("vec idle busy",  int'(busy),  0);
        end

        // Three words back to back, no gap between them.
        do_reset();
        msb_first = 1'b0; gray_en = 1'b0; diff_en = 1'b0;
        fifo.push_back(8'h00); fifo.push_back(8'hFF); fifo.push_back(8'h1B);
        for (int j = 0; j < 4; j++) exp_ph.push_back(0);
        for (int j = 0; j < 4; j++) exp_ph.push_back(3);
        for (int j = 0; j < 4; j++) exp_ph.push_back(3 - j);
        run_stream(100, -1, 0, "b2b");

        // Enable low for 5 cycles starting at the 2nd clock of symbol 1.
        do_reset();
        fifo.push_back(8'hB4);
        exp_ph.push_back(0); exp_ph.push_back(1); exp_ph.push_back(3); exp_ph.push_back(2);
        run_stream(100, 5, 5, "stall");

        // Randomized bursts; accumulator carries across bursts.
        do_reset();
        for (int b = 0; b < 40; b++) begin
            msb_first = 1'($urandom_range(0, 1));
            gray_en   = 1'($urandom_range(0, 1));
            diff_en   = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            for (int w = 0; w < n; w++)
                model_word(8'($urandom), msb_first, gray_en, diff_en);
            if ($urandom_range(0, 3) == 0)
                run_stream(100, int'($urandom_range(0, 20)), int'($urandom_range(1, 6)), "rand");
            else
                run_stream(int'($urandom_range(50, 100)), -1, 0, "rand");
        end

        // k=1, one clock per symbol: a new phase every cycle.
        do_reset();
        a5 = 8'hA5;
        sample1 = a5; empty1 = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            b1 = (int'(a5) >> j) & 1;
            chk("k1 phase",  int'(phase1),  b1);
            chk("k1 strobe", int'(strobe1), 1);
            chk("k1 read",   int'(read1),   (j == 0) ? 1 : 0);
            chk("k1 busy",   int'(busy1),   1);
            if (j == 0) empty1 = 1'b1;
            @(negedge clk);
        end
        chk("k1 underrun",   int'(underrun1), 1);
        chk("k1 end busy",   int'(busy1),     0);
        chk("k1 hold phase", int'(phase1),    1);

        // Asynchronous reset in the middle of a word.
        empty1 = 1'b0;
        @(negedge clk);
        empty1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("k1 mid busy",  int'(busy1),  1);
        chk("k1 mid phase", int'(phase1), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst phase1",  int'(phase1),  0);
        chk("rst busy1",   int'(busy1),   0);
        chk("rst read1",   int'(read1),   0);
        chk("rst strobe1", int'(strobe1), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("post rst read1", int'(read1), 0);
            chk("post rst busy1", int'(busy1), 0);
        end
        empty1 = 1'b0;
        @(negedge clk);
        empty1 = 1'b1;
        chk("restart read1",  int'(read1),  1);
        chk("restart busy1",  int'(busy1),  1);
        chk("restart phase1", int'(phase1), 1);
        repeat (10) @(negedge clk);
        chk("restart done busy1", int'(busy1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        checks++; errors++;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
